display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Scan controller for the 8-digit active-LOW 7-segment display. Paces digit slots from the system clock.
//  Inserts anti-ghosting dead time and applies PWM brightness. Double-buffers the 8-digit BCD
//  word so a display update never tears mid-frame. Sits between the lifetime-count logic and the segment decoder.
// PARAMETERS
//  CLK_HZ       100_000_000  system clock frequency
//  SCAN_HZ      1000         digit-slot rate; DIGIT_PERIOD = CLK_HZ/SCAN_HZ cycles (>= DEAD_CYCLES+2)
//  DEAD_CYCLES  64           cycles at start of each slot with all anodes off
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous, active-high reset
//  enable         in   1   0 = display dark, scan held at digit 0
//  brightness     in   4   PWM level, 0 = dark ... 15 = full
//  load_valid     in   1   new BCD word offered
//  load_data      in   32  8 BCD nibbles, [3:0] = digit 0 (least significant)
//  load_ready     out  1   pending buffer empty, can accept
//  anodes         out  8   active-LOW digit enables, at most one bit low
//  current_digit  out  3   digit index of the current slot
//  digit_bcd      out  4   shadow nibble for current_digit
//  digit_blank    out  1   current digit suppressed (leading zero)
//  frame_start    out  1   1-cycle pulse when digit 0 slot begins
// BEHAVIOUR
//  Reset: anodes=8'hFF, current_digit=0, digit_bcd=0, digit_blank=0, frame_start=0, load_ready=1,
//   shadow=0, pending empty, slot counter cnt=0, state=S_OFF.
//  States: S_OFF, S_DEAD, S_ON, S_TAIL. cnt runs 0..DIGIT_PERIOD-1 and wraps.
//   S_OFF: enable=0. cnt=0, digit=0, anodes=FF. On enable=1, go to S_DEAD with cnt=0 and pulse frame_start.
//   S_DEAD: cnt < DEAD_CYCLES, anodes=FF.
//   S_ON: DEAD_CYCLES <= cnt < DEAD_CYCLES+on_len.
//     anodes = ~(1<<current_digit), or FF when digit_blank is set.
//   S_TAIL: remaining cycles, anodes=FF. Skipped when on_len fills the slot.
//   Slot end (cnt=DIGIT_PERIOD-1): digit wraps 7->0 and returns to S_DEAD.
//   Entering digit 0 pulses frame_start.
//   enable=0 in any state: S_OFF on the next cycle; anodes=FF that same edge.
//  on_len = ((DIGIT_PERIOD-DEAD_CYCLES)*(brightness_q+1))>>4. Product width >= clog2(DIGIT_PERIOD)+5, no truncation.
//   brightness_q is brightness sampled at each frame start, then held for the whole frame.
//   brightness 0 gives on_len=0 when DIGIT_PERIOD-DEAD_CYCLES < 16. Otherwise the display is dim, not off.
//  Anode outputs are registered, so there is 1 cycle of latency from a state/cnt change to the pins.
//   digit_bcd and digit_blank are registered alongside anodes.
//  Load handshake: transfer when load_valid & load_ready. load_ready = ~pending_valid.
//   Data goes into pending. At the last cycle of the digit-7 slot (or on S_OFF->S_DEAD), shadow<=pending if valid, then pending clears.
//   Accept and swap in the same cycle: shadow takes the old pending; the new word becomes pending.
//   Shadow never changes mid-frame.
//  Reset mid-frame: all state returns to reset values and any pending word is discarded.
// CONFIGURATION
//  DISP_LZ_BLANK_EN defined: digit i (i>0) is blanked when shadow nibbles i..7 are all 0.
//   Digit 0 is never blanked.
//  DISP_LZ_BLANK_EN undefined: digit_blank is tied 0 and all digits light.
// STRUCTURE
//  display_pkg: NUM_DIGITS=8, ANODES_OFF=8'hFF, scan_state_t enum {S_OFF,S_DEAD,S_ON,S_TAIL}.
//  Sub-module scan_timer: slot counter cnt, slot_end and frame_end strobes.
//  The top level holds the FSM, buffers, blanking logic and output registers.
// TESTING (CLK_HZ=1600, SCAN_HZ=100 -> DIGIT_PERIOD=16, DEAD_CYCLES=2)
//  1 Reset, enable=1, brightness=15: each slot has 2 cycles FF, then 14 cycles with one anode low.
//    Order FE,FD,...,7F; frame_start every 128 cycles.
//  2 brightness=7: on_len=7. 2 FF, 7 low, 7 FF per slot. Change to 15 mid-frame: takes effect only at the next frame_start.
//  3 Load 32'h1234_5678 mid-frame: load_ready drops. digit_bcd is unchanged until the next frame.
//    After the swap, digit0=8 ... digit7=1, and load_ready=1.
//  4 Load during the last cycle of the digit-7 slot, with a word already pending:
//    shadow takes the old word; the new word is displayed one frame later.
//  5 With DISP_LZ_BLANK_EN, load 32'h0000_0042: digits 2..7 have digit_blank=1 and anodes FF.
//    Load 0: only digit 0 lights.
//  6 Drop enable mid-S_ON, then assert rst mid-frame: anodes=FF next edge, digit=0, pending cleared, load_ready=1.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the 8-digit multiplexed 7-segment display scan path.
package display_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] ANODES_OFF = 8'hFF;

  typedef enum logic [1:0] {S_OFF, S_DEAD, S_ON, S_TAIL} scan_state_t;

  function automatic logic [7:0] digit_anode(input logic [2:0] d);
    return ~(8'b1 << d);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Digit-slot pacing counter: cnt runs 0..PERIOD-1 while running, held at 0 otherwise.
module scan_timer
  import display_pkg::*;
#(
  parameter int PERIOD = 16,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic [2:0]       digit_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             slot_end_o,
  output logic             frame_end_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i && (cnt_q != CNT_LAST)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o       = cnt_q;
  assign slot_end_o  = run_i && (cnt_q == CNT_LAST);
  assign frame_end_o = slot_end_o && (digit_i == 3'(NUM_DIGITS - 1));

endmodule

// File: rtl/display_scan_ctrl.sv
// Display scan controller: dead time, PWM brightness, double-buffered BCD word.
// Optional leading-zero blanking enabled by defining DISP_LZ_BLANK_EN.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int DEAD_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  brightness,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic [7:0]  anodes,
  output logic [2:0]  current_digit,
  output logic [3:0]  digit_bcd,
  output logic        digit_blank,
  output logic        frame_start
);

  localparam int DIGIT_PERIOD = CLK_HZ / SCAN_HZ;
  localparam int CNT_W        = $clog2(DIGIT_PERIOD);
  localparam int PROD_W       = CNT_W + 5;

  localparam logic [PROD_W-1:0] ACTIVE    = PROD_W'(DIGIT_PERIOD - DEAD_CYCLES);
  localparam logic [PROD_W-1:0] DEAD_EXT  = PROD_W'(DEAD_CYCLES);
  localparam logic [PROD_W-1:0] ONE       = PROD_W'(1);
  localparam logic [CNT_W-1:0]  DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  scan_state_t       state_q;
  logic [CNT_W-1:0]  cnt;
  logic              slot_end, frame_end, run, swap, accept, blank;
  logic [2:0]        digit_q;
  logic [3:0]        bright_q;
  logic [31:0]       shadow_q, pend_q;
  logic              pend_vld_q;
  logic [7:0]        anodes_q;
  logic [3:0]        bcd_q;
  logic              blank_q, frame_start_q;
  logic [PROD_W-1:0] on_end;

  function automatic logic [PROD_W-1:0] calc_on_len(input logic [3:0] b);
    logic [PROD_W-1:0] prod;
    prod = ACTIVE * PROD_W'({1'b0, b} + 5'd1);
    return prod >> 4;
  endfunction

  assign on_end = DEAD_EXT + calc_on_len(bright_q);
  assign run    = enable && (state_q != S_OFF);
  assign swap   = enable && ((state_q == S_OFF) || frame_end);
  assign accept = load_valid && !pend_vld_q;

`ifdef DISP_LZ_BLANK_EN
  assign blank = (digit_q != 3'd0) && ((shadow_q >> {digit_q, 2'b00}) == 32'd0);
`else
  assign blank = 1'b0;
`endif

  scan_timer #(
    .PERIOD (DIGIT_PERIOD),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .run_i       (run),
    .digit_i     (digit_q),
    .cnt_o       (cnt),
    .slot_end_o  (slot_end),
    .frame_end_o (frame_end)
  );

  // Scan FSM; pin outputs are registered from the current state, one cycle behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_OFF;
      digit_q       <= 3'd0;
      bright_q      <= 4'd0;
      frame_start_q <= 1'b0;
      anodes_q      <= ANODES_OFF;
      bcd_q         <= 4'd0;
      blank_q       <= 1'b0;
    end else begin
      bcd_q    <= shadow_q[{digit_q, 2'b00} +: 4];
      blank_q  <= blank;
      anodes_q <= (enable && (state_q == S_ON) && !blank) ? digit_anode(digit_q) : ANODES_OFF;
      if (!enable) begin
        state_q       <= S_OFF;
        digit_q       <= 3'd0;
        frame_start_q <= 1'b0;
      end else begin
        frame_start_q <= swap;
        if (swap) bright_q <= brightness;
        if (slot_end) digit_q <= digit_q + 1'b1;
        unique case (state_q)
          S_OFF:  state_q <= S_DEAD;
          S_DEAD: if (cnt == DEAD_LAST) state_q <= (on_end == DEAD_EXT) ? S_TAIL : S_ON;
          S_ON: begin
            if (slot_end)                          state_q <= S_DEAD;
            else if (PROD_W'(cnt) + ONE == on_end) state_q <= S_TAIL;
          end
          S_TAIL: if (slot_end) state_q <= S_DEAD;
        endcase
      end
    end
  end

  // Double buffer: shadow only changes at a frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= 32'd0;
      pend_vld_q <= 1'b0;
    end else begin
      if (swap && pend_vld_q) shadow_q <= pend_q;
      if (accept)             pend_vld_q <= 1'b1;
      else if (swap)          pend_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pend_q <= load_data;
  end

  assign load_ready    = !pend_vld_q;
  assign anodes        = anodes_q;
  assign current_digit = digit_q;
  assign digit_bcd     = bcd_q;
  assign digit_blank   = blank_q;
  assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with a frame-position reference model (P=16, dead=2).
module tb_display_scan_ctrl;

  localparam int P     = 16;
  localparam int DEAD  = 2;
  localparam int ACT   = P - DEAD;
  localparam int FRAME = 8 * P;
`ifdef DISP_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk, rst, enable, load_valid, load_ready, digit_blank, frame_start;
  logic [3:0]  brightness, digit_bcd;
  logic [31:0] load_data;
  logic [7:0]  anodes;
  logic [2:0]  current_digit;

  display_scan_ctrl #(
    .CLK_HZ      (1600),
    .SCAN_HZ     (100),
    .DEAD_CYCLES (DEAD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .brightness    (brightness),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .anodes        (anodes),
    .current_digit (current_digit),
    .digit_bcd     (digit_bcd),
    .digit_blank   (digit_blank),
    .frame_start   (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position within the frame, frame brightness, buffers
  bit          m_on = 1'b0;
  int          m_t  = 0;
  logic [3:0]  m_bq = 4'd0;
  logic [31:0] m_sh = 32'd0, m_pd = 32'd0;
  bit          m_pv = 1'b0;
  logic [7:0]  e_an;
  logic [3:0]  e_bcd;
  logic        e_blank, e_fs;
  logic [2:0]  e_dig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit lz(input logic [31:0] sh, input int d);
    bit all0 = 1'b1;
    if (!LZ || d == 0) return 1'b0;
    for (int i = d; i < 8; i++) if (sh[4*i +: 4] != 4'd0) all0 = 1'b0;
    return all0;
  endfunction

  task automatic tick();
    int d, c, onl;
    bit fstart, acc;
    if (rst) begin
      e_an = 8'hFF; e_bcd = 4'd0; e_blank = 1'b0; e_fs = 1'b0;
      m_on = 1'b0; m_t = 0; m_bq = 4'd0; m_sh = 32'd0; m_pv = 1'b0;
    end else begin
      d   = m_on ? m_t / P : 0;
      c   = m_t % P;
      onl = (ACT * (int'(m_bq) + 1)) / 16;
      e_bcd   = m_sh[4*d +: 4];
      e_blank = lz(m_sh, d);
      if (enable && m_on && c >= DEAD && c < DEAD + onl && !e_blank) e_an = ~(8'd1 << d);
      else e_an = 8'hFF;
      fstart = enable && (!m_on || m_t == FRAME - 1);
      e_fs   = fstart;
      acc    = load_valid && !m_pv;
      if (fstart && m_pv) begin m_sh = m_pd; m_pv = 1'b0; end
      if (acc) begin m_pd = load_data; m_pv = 1'b1; end
      if (!enable) begin m_on = 1'b0; m_t = 0; end
      else if (!m_on) begin m_on = 1'b1; m_t = 0; m_bq = brightness; end
      else begin
        m_t = (m_t + 1) % FRAME;
        if (m_t == 0) m_bq = brightness;
      end
    end
    e_dig = m_on ? 3'(m_t / P) : 3'd0;
    @(posedge clk);
    #1;
    chk("anodes", anodes, e_an);
    chk("digit_bcd", digit_bcd, e_bcd);
    chk("digit_blank", digit_blank, e_blank);
    chk("frame_start", frame_start, e_fs);
    chk("current_digit", current_digit, e_dig);
    chk("load_ready", load_ready, !m_pv);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_t(input int target);
    int n = 0;
    do begin tick(); n++; end while (!(m_on && m_t == target) && n < 400);
    if (!(m_on && m_t == target)) begin
      n_fail++;
      $error("FAIL wait_t: frame position %0d not reached, stopped at %0d", target, m_t);
    end
  endtask

  task automatic load(input logic [31:0] w);
    bit acc = 1'b0;
    int n = 0;
    load_valid = 1'b1;
    load_data  = w;
    do begin acc = !m_pv; tick(); n++; end while (!acc && n < 400);
    load_valid = 1'b0;
    if (!acc) begin
      n_fail++;
      $error("FAIL load_timeout: word %0h not accepted", w);
    end
  endtask

  initial begin
    logic [7:0]  ea;
    logic [31:0] wa, wb;
    int          fs_seen, last;
    rst = 1'b1; enable = 1'b0; brightness = 4'd0; load_valid = 1'b0; load_data = 32'd0;
    run_n(3);
    chk("rst_anodes", anodes, 32'hFF);
    chk("rst_digit", current_digit, 0);
    chk("rst_bcd", digit_bcd, 0);
    chk("rst_blank", digit_blank, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_ready", load_ready, 1);
    rst = 1'b0;
    tick();

    // Full brightness: frame_start every 128 cycles, 2 dark + 14 lit per slot
    brightness = 4'd15; enable = 1'b1;
    fs_seen = 0; last = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (frame_start) begin
        if (last >= 0) chk("fs_gap", i - last, FRAME);
        last = i;
        fs_seen++;
      end
    end
    chk("fs_count", fs_seen, 3);
    for (int d = 0; d < 8; d++) begin
      wait_t(P * d + 2);
      chk("t1_dead", anodes, 32'hFF);
      wait_t(P * d + 3);
      ea = ~(8'd1 << d);
      chk("t1_lit", anodes, ea);
    end

    // Brightness 7: 7 lit cycles, mid-frame change waits for the next frame
    brightness = 4'd7;
    wait_t(0);
    for (int d = 0; d < 3; d++) begin
      wait_t(P * d + 9);
      ea = ~(8'd1 << d);
      chk("t2_lit", anodes, ea);
      wait_t(P * d + 10);
      chk("t2_tail", anodes, 32'hFF);
    end
    brightness = 4'd15;
    wait_t(3 * P + 10);
    chk("t2_held", anodes, 32'hFF);
    wait_t(P + 10);
    chk("t2_new", anodes, 32'hFD);

    // Mid-frame load only shows after the next frame boundary
    load(32'h1234_5678);
    chk("t3_ready_low", load_ready, 0);
    wait_t(3 * P + 5);
    chk("t3_unchanged", digit_bcd, 0);
    wait_t(0);
    chk("t3_ready_high", load_ready, 1);
    for (int d = 0; d < 8; d++) begin
      wait_t(P * d + 5);
      chk("t3_digit", digit_bcd, 8 - d);
    end

    // Offer a word in the last digit-7 cycle while one is pending
    wa = 32'h8765_4321; wb = 32'h1357_9246;
    wait_t(20);
    load(wa);
    wait_t(FRAME - 1);
    load(wb);
    chk("t4_ready_low", load_ready, 0);
    wait_t(5);
    chk("t4_old_word", digit_bcd, wa[3:0]);
    wait_t(0);
    wait_t(5);
    chk("t4_new_word", digit_bcd, wb[3:0]);

    // Leading-zero blanking (only active in that build)
    load(32'h0000_0042);
    wait_t(0);
    for (int d = 0; d < 8; d++) begin
      wait_t(P * d + 8);
      ea = (LZ && d >= 2) ? 8'hFF : ~(8'd1 << d);
      chk("t5_anodes", anodes, ea);
      chk("t5_blank", digit_blank, LZ && d >= 2);
    end
    load(32'h0000_0000);
    wait_t(0);
    for (int d = 0; d < 8; d++) begin
      wait_t(P * d + 8);
      ea = (LZ && d >= 1) ? 8'hFF : ~(8'd1 << d);
      chk("t5_zero", anodes, ea);
    end

    // Brightness 0 with 14-cycle active window: fully dark
    brightness = 4'd0;
    wait_t(0);
    wait_t(3 * P + 5);
    chk("dark", anodes, 32'hFF);

    // Randomised brightness, loads and enable drops
    for (int i = 0; i < 10; i++) begin
      run_n($urandom_range(5, 200));
      brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) load($urandom);
      if ($urandom_range(0, 4) == 0) begin
        enable = 1'b0;
        run_n($urandom_range(1, 5));
        enable = 1'b1;
      end
    end

    // Enable drop mid-lit, then reset mid-frame discards the pending word
    brightness = 4'd15;
    wait_t(3 * P + 6);
    enable = 1'b0;
    tick();
    chk("t6_off_anodes", anodes, 32'hFF);
    chk("t6_off_digit", current_digit, 0);
    enable = 1'b1;
    load(32'h0000_0000);
    wait_t(0);
    wait_t(20);
    load(32'h0000_0009);
    chk("t6_pending", load_ready, 0);
    wait_t(50);
    rst = 1'b1;
    tick();
    chk("t6_rst_ready", load_ready, 1);
    chk("t6_rst_anodes", anodes, 32'hFF);
    chk("t6_rst_digit", current_digit, 0);
    rst = 1'b0;
    wait_t(5);
    chk("t6_discarded", digit_bcd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
